// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - instruction opcodes seen in IR[31:26]
//   - ALUOp, ALUSrcB and PCSource encodings driven to the datapath
//   - 4-bit FSM state enum (exported on state_dbg)
//   - packed control word produced by the state decoder
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
    logic       retire;
  } ctrl_word_t;

  // Opcodes the FSM knows how to sequence; anything else traps.
  function automatic logic is_legal_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/unidad_control_multiciclo_if.sv
// unidad_control_multiciclo_if
// Bundle between the multicycle control unit and the shared datapath.
//   master : control unit (consumes opcode/mem_ready, drives all enables,
//            mux selects, retire, illegal and state_dbg)
//   slave  : datapath / memory side (the mirror image)
interface unidad_control_multiciclo_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       retire;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           retire, illegal, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           retire, illegal, state_dbg
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
// Purely combinational state -> control-word table.
//   state     : current FSM state
//   mem_ready : effective memory-ready (already forced high when unused)
//   ctrl      : control word for this cycle; fields not set for a state are 0
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed, together
        // with the IR load, on the cycle memory actually returns the word.
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      default: begin
        // S_TRAP and unused encodings: everything stays quiet.
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo
// Multicycle MIPS control FSM. Holds the state register, next-state logic
// and the sticky illegal-opcode flag; the per-state control word comes from
// mc_ctrl_decode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : master side of unidad_control_multiciclo_if (opcode, mem_ready
//           in; datapath enables, mux selects, retire, illegal, state_dbg out)
// Parameter USE_MEM_READY: 1 = memory states wait on mem_ready,
//                          0 = memory always completes in one cycle.
module unidad_control_multiciclo
  import mips_ctrl_pkg::*;
#(
  parameter int USE_MEM_READY = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  unidad_control_multiciclo_if.master        bus
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       mem_ready_eff;
  ctrl_word_t ctrl_raw;
  ctrl_word_t ctrl_out;

  generate
    if (USE_MEM_READY != 0) begin : g_mem_wait
      assign mem_ready_eff = bus.mem_ready;
    end else begin : g_mem_nowait
      assign mem_ready_eff = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready_eff ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready_eff ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready_eff ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      // Any corrupted encoding recovers by restarting the fetch.
      default:  state_d = S_FETCH;
    endcase
  end

  // Set on the edge that enters TRAP so the flag is visible in the same
  // cycle as state_dbg shows TRAP.
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready_eff),
    .ctrl      (ctrl_raw)
  );

  // The state register already sits at FETCH during reset, whose word has
  // MemRead and ALUSrcB set; gate with rst_n so every strobe and select is
  // zero while reset is held, and drops in the very cycle reset asserts.
  always_comb begin
    ctrl_out = rst_n ? ctrl_raw : '0;
  end

  assign bus.PCWrite     = ctrl_out.pc_write;
  assign bus.PCWriteCond = ctrl_out.pc_write_cond;
  assign bus.IorD        = ctrl_out.iord;
  assign bus.MemRead     = ctrl_out.mem_read;
  assign bus.MemWrite    = ctrl_out.mem_write;
  assign bus.IRWrite     = ctrl_out.ir_write;
  assign bus.MemToReg    = ctrl_out.mem_to_reg;
  assign bus.RegDst      = ctrl_out.reg_dst;
  assign bus.RegWrite    = ctrl_out.reg_write;
  assign bus.ALUSrcA     = ctrl_out.alu_src_a;
  assign bus.ALUSrcB     = ctrl_out.alu_src_b;
  assign bus.ALUOp       = ctrl_out.alu_op;
  assign bus.PCSource    = ctrl_out.pc_source;
  assign bus.retire      = ctrl_out.retire;
  assign bus.illegal     = illegal_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Testbench for unidad_control_multiciclo. Each instruction is expanded
// into an expected per-cycle script (opcode, mem_ready, control word,
// state) built from the per-phase behaviour of a multicycle MIPS; the
// script drives the DUT and is compared cycle by cycle. Latency and
// retire count per instruction are checked against a plain latency table.
module tb_unidad_control_multiciclo;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  unidad_control_multiciclo_if bus_if ();

  unidad_control_multiciclo #(.USE_MEM_READY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [18:0] word;
    state_e      st;
  } cyc_t;

  cyc_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,retire,illegal}
  function automatic logic [18:0] w(input logic pcw, pcwc, iord, mrd, mwr, irw,
                                    m2r, rdst, rw, asa, input logic [1:0] asb,
                                    input logic [2:0] aop, input logic [1:0] pcs,
                                    input logic ret, ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ret, ill};
  endfunction

  function automatic logic [18:0] obs_word();
    return {bus_if.PCWrite, bus_if.PCWriteCond, bus_if.IorD, bus_if.MemRead,
            bus_if.MemWrite, bus_if.IRWrite, bus_if.MemToReg, bus_if.RegDst,
            bus_if.RegWrite, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUOp,
            bus_if.PCSource, bus_if.retire, bus_if.illegal};
  endfunction

  task automatic push(input logic [5:0] op, input logic mr, input logic [18:0] wd, input state_e st);
    cyc_t c;
    c.op = op; c.mr = mr; c.word = wd; c.st = st;
    exp_q.push_back(c);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Cycles from fetch to retire with memory always ready.
  function automatic int base_latency(input logic [5:0] op);
    case (op)
      OP_LW:                    return 5;
      OP_SW, OP_RTYPE, OP_ADDI: return 4;
      default:                  return 3;
    endcase
  endfunction

  // Build the script for one instruction. fw = fetch wait cycles,
  // mw = memory wait cycles (lw/sw only).
  task automatic build_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++)
      push(6'($urandom), 1'b0, w(0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0,0), S_FETCH);
    push(6'($urandom), 1'b1, w(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,2'b00,0,0), S_FETCH);
    push(op, rbit(), w(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,0), S_DECODE);
    case (op)
      OP_RTYPE: begin
        push(op, rbit(), w(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0), S_EXEC);
        push(op, rbit(), w(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,1,0), S_ALUWB);
      end
      OP_LW: begin
        push(op, rbit(), w(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0), S_MEMADR);
        for (int i = 0; i < mw; i++)
          push(op, 1'b0, w(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), S_MEMRD);
        push(op, 1'b1, w(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), S_MEMRD);
        push(op, rbit(), w(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,1,0), S_MEMWB);
      end
      OP_SW: begin
        push(op, rbit(), w(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0), S_MEMADR);
        for (int i = 0; i < mw; i++)
          push(op, 1'b0, w(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), S_MEMWR);
        push(op, 1'b1, w(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,1,0), S_MEMWR);
      end
      OP_BEQ:
        push(op, rbit(), w(0,1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,1,0), S_BRANCH);
      OP_J:
        push(op, rbit(), w(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0), S_JUMP);
      OP_ADDI: begin
        push(op, rbit(), w(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0), S_ADDIEX);
        push(op, rbit(), w(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,1,0), S_ADDIWB);
      end
      default:
        for (int i = 0; i < 20; i++)
          push(6'($urandom), rbit(), w(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1), S_TRAP);
    endcase
  endtask

  // Play the script: drive just after the rising edge, compare at the
  // falling edge.
  task automatic run_script(output int cycles, output int ret_cnt, output int ret_at);
    cyc_t c;
    cycles = 0; ret_cnt = 0; ret_at = -1;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      bus_if.opcode    = c.op;
      bus_if.mem_ready = c.mr;
      @(negedge clk);
      check_val($sformatf("word %s cyc%0d", c.st.name(), cycles), 32'(obs_word()), 32'(c.word));
      check_val($sformatf("state %s cyc%0d", c.st.name(), cycles), 32'(bus_if.state_dbg), 32'(c.st));
      if (bus_if.retire === 1'b1) begin
        ret_cnt++;
        if (ret_at < 0) ret_at = cycles;
      end
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int cycles, ret_cnt, ret_at, exp_lat;
    logic legal;
    legal = op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    build_instr(op, fw, mw);
    run_script(cycles, ret_cnt, ret_at);
    check_val($sformatf("retire_cnt op%02h", op), 32'(ret_cnt), legal ? 32'd1 : 32'd0);
    if (legal) begin
      exp_lat = base_latency(op) + fw + ((op == OP_LW || op == OP_SW) ? mw : 0);
      check_val($sformatf("latency op%02h", op), 32'(ret_at + 1), 32'(exp_lat));
    end
    $display("instr op=%02h fetch_wait=%0d mem_wait=%0d cycles=%0d retires=%0d",
             op, fw, mw, cycles, ret_cnt);
  endtask

  task automatic check_in_reset(input string tag);
    check_val({tag, " word"}, 32'(obs_word()), 32'd0);
    check_val({tag, " state"}, 32'(bus_if.state_dbg), 32'(S_FETCH));
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    int cyc, rc, ra;
    legal_ops[0] = OP_RTYPE; legal_ops[1] = OP_LW;  legal_ops[2] = OP_SW;
    legal_ops[3] = OP_BEQ;   legal_ops[4] = OP_J;   legal_ops[5] = OP_ADDI;

    rst_n = 1'b0;
    bus_if.opcode    = 6'h00;
    bus_if.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_in_reset("reset");
    rst_n = 1'b1;

    // Directed sequence from the test plan.
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_ADDI, 1, 0);

    // Randomized instruction stream with random memory waits.
    for (int n = 0; n < 150; n++)
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3));

    // Reset while an lw is waiting in MEMRD.
    push(OP_LW, 1'b1, w(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,2'b00,0,0), S_FETCH);
    push(OP_LW, 1'b1, w(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,0), S_DECODE);
    push(OP_LW, 1'b0, w(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0), S_MEMADR);
    push(OP_LW, 1'b0, w(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), S_MEMRD);
    run_script(cyc, rc, ra);
    bus_if.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_in_reset("midmemrd rst c0");
    @(posedge clk);
    #1;
    check_in_reset("midmemrd rst c1");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset mid-MEMRD applied for 2 cycles");
    run_instr(OP_LW, 1, 0);

    // Illegal opcode: trap, then only reset recovers.
    run_instr(6'h3F, 0, 0);
    rst_n = 1'b0;
    #1;
    check_in_reset("trap rst");
    check_val("illegal cleared", 32'(bus_if.illegal), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(OP_RTYPE, 0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/unidad_control_multiciclo.md
Name: unidad_control_multiciclo

Overview:
- Multicycle MIPS control FSM. Sequences the shared datapath (PC, IR, register file, ALU, unified instruction/data memory) over 3–5 cycles per instruction.
- Replaces single-cycle opcode decode with Moore-style per-state control words.
- Adds a memory wait handshake and an illegal-opcode trap.
- Sits between the IR opcode field and all datapath enables/muxes.

Parameters:
- USE_MEM_READY, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (beq)
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemToReg  out  1  write-back source: 0=ALUOut, 1=MDR
- RegDst  out  1  destination: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- ALUOp  out  3  000=add, 001=sub, 010=funct-decode (R-type)
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- retire  out  1  one-cycle pulse in final state of each instruction
- illegal  out  1  sticky illegal-opcode flag
- state_dbg  out  4  current state encoding

Behaviour:
- Opcodes: R=6'h00, lw=6'h23, sw=6'h2B, beq=6'h04, j=6'h02, addi=6'h08.
- Reset: state=FETCH, illegal=0. While rst_n=0, all write/strobe outputs (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, retire) are forced 0. Mux selects and ALUOp are 0.
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=0: stay in FETCH. mem_ready=1: go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by opcode:
  - lw/sw → MEMADR
  - R → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - other → TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then → MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1, retire=1 → FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for mem_ready. retire=mem_ready. mem_ready=1 → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010 → ALUWB.
- ALUWB: RegDst=1, MemToReg=0, RegWrite=1, retire=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, retire=1 → FETCH.
- JUMP: PCWrite=1, PCSource=10, retire=1 → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=000 → ADDIWB.
- ADDIWB: RegDst=0, MemToReg=0, RegWrite=1, retire=1 → FETCH.
- TRAP: illegal set (sticky); all strobes 0; stays in TRAP until reset.
- Latencies with mem_ready always 1:
  - lw 5 cycles; sw, R, addi 4 cycles; beq, j 3 cycles.
  - Each memory wait cycle adds 1.
- Strobes are Moore outputs of the state register, except the mem_ready-qualified IRWrite/PCWrite/retire, which are combinational from mem_ready.
- Reset asserted mid-instruction: immediate return to FETCH, no partial write-back. Pending memory strobes drop in the same cycle.
- Unreachable state encodings → FETCH on the next edge.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp encodings (ALU_ADD=000, ALU_SUB=001, ALU_FUNCT=010)
  - ALUSrcB/PCSource encodings
  - 4-bit state enum S_FETCH..S_TRAP
- Optional sub-module mc_ctrl_decode: pure combinational state→control-word table. The top keeps the state register, next-state logic and illegal flag.

Test Plan:
- Reset mid-MEMRD (rst_n low 2 cycles) → state_dbg=FETCH and MemRead=0 while low; first cycle after release is FETCH with MemRead=1.
- Opcode 6'h00, mem_ready=1 → FETCH, DECODE, EXEC (ALUOp=010), ALUWB (RegWrite=1, RegDst=1, retire=1); back in FETCH on cycle 5.
- Opcode 6'h23, mem_ready low 3 cycles in MEMRD → MemRead=1, IorD=1 held 4 cycles; MEMWB asserts MemToReg=1, RegWrite=1; total 8 cycles.
- Opcode 6'h2B then 6'h04 back-to-back → MemWrite=1 for exactly 1 cycle. Then BRANCH with PCWriteCond=1, PCSource=01, ALUOp=001; retire pulses twice.
- Opcode 6'h02 → JUMP with PCWrite=1, PCSource=10; 3-cycle instruction.
- Opcode 6'h3F → TRAP, illegal=1, no strobes for 20 cycles; cleared only by rst_n=0.
